mem_access_seq: RTL and testbench

Parametrised CPU-side memory access sequencer between the core's load/store path and a synchronous single-port memory of `LANES` bytes per word. It accepts one byte, halfword or word access at a time and splits it into one or more aligned memory beats. For loads it assembles and sign/zero-extends the result; for stores it generates the byte-lane write enables. It reports completion through `o_done`, and the core stalls on `o_ready` low.

---
 rtl/mem_access_seq.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_seq.sv
// mem_access_seq: splits CPU byte/halfword/word accesses into aligned beats on a LANES-byte memory.
// Define MEM_ACCESS_SEQ_ALIGN_CHECK_EN to reject misaligned or size=11 requests through o_err.
module mem_access_seq #(
  parameter int MEM_DEPTH = 2**12,
  parameter int LANES     = 2,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*LANES),
  localparam int MEM_AW     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic                  o_err,
  input  logic [0:LANES-1][7:0] i_mem_do,
  output logic [0:LANES-1][7:0] o_mem_di,
  output logic [MEM_AW-1:0]     o_mem_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_rd_en,
  output logic [0:LANES-1]      o_mem_wr_en
);
  localparam int LANE_BITS = $clog2(LANES);

  // states: IDLE accept | ISSUE drive beat | WAIT last read data | DONE pulse | ERR reject pulse
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

  state_t                state_q, state_n;
  logic [1:0]            beat_q, beat_n;
  logic                  we_q, we_n, sgn_q, sgn_n;
  logic [1:0]            sz_q, sz_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [31:0]           wdata_q, wdata_n, acc_q, acc_n, rdata_n;

  logic                  ready_n, done_n, err_n, en_n, rd_en_n;
  logic [0:LANES-1]      wr_en_n;
  logic [0:LANES-1][7:0] di_n;
  logic [MEM_AW-1:0]     maddr_n;

  logic                  bad, last, issue_n;
  logic [1:0]            req_sz, cap, off_q, off_n;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LANES*8-1:0]    mem_le;
  logic [31:0]           word_val, sub_val;

  function automatic logic [31:0] extend(input logic [1:0] sz, input logic sgn, input logic [31:0] v);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {{24{sgn & v[7]}}, v[7:0]};
      2'b01:   r = {{16{sgn & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      sz_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      acc_q       <= '0;
      o_ready     <= 1'b1;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= '0;
      o_mem_en    <= 1'b0;
      o_mem_rd_en <= 1'b0;
      o_mem_wr_en <= '0;
      o_mem_di    <= '0;
      o_mem_addr  <= '0;
    end else begin
      state_q     <= state_n;
      beat_q      <= beat_n;
      we_q        <= we_n;
      sgn_q       <= sgn_n;
      sz_q        <= sz_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      acc_q       <= acc_n;
      o_ready     <= ready_n;
      o_done      <= done_n;
      o_err       <= err_n;
      o_rdata     <= rdata_n;
      o_mem_en    <= en_n;
      o_mem_rd_en <= rd_en_n;
      o_mem_wr_en <= wr_en_n;
      o_mem_di    <= di_n;
      o_mem_addr  <= maddr_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    beat_n   = beat_q;
    we_n     = we_q;
    sgn_n    = sgn_q;
    sz_n     = sz_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    acc_n    = acc_q;
    rdata_n  = o_rdata;
    bad      = 1'b0;
    req_sz   = i_size;
    req_addr = i_addr;
`ifdef MEM_ACCESS_SEQ_ALIGN_CHECK_EN
    bad = (i_size == 2'b11) || (i_size == 2'b01 && i_addr[0]) ||
          (i_size == 2'b10 && i_addr[1:0] != 2'b00);
`else
    if (i_size == 2'b11) req_sz = 2'b10;
    case (req_sz)
      2'b01:   req_addr[0]   = 1'b0;
      2'b10:   req_addr[1:0] = 2'b00;
      default: ;
    endcase
`endif

    // little-endian view of the returned word: lane k is byte k
    mem_le = '0;
    for (int k = 0; k < LANES; k++) mem_le[8*k +: 8] = i_mem_do[k];
    cap      = (state_q == WAIT) ? beat_q : beat_q - 2'd1;
    off_q    = 2'(addr_q[LANE_BITS-1:0]);
    word_val = acc_q | (32'(mem_le) << (8*LANES*cap));
    sub_val  = 32'(mem_le >> (8*off_q));
    last     = (sz_q == 2'b10 && LANES == 2) ? (beat_q == 2'd1) : 1'b1;

    case (state_q)
      IDLE: begin
        if (i_req) begin
          we_n    = i_we;
          sz_n    = req_sz;
          sgn_n   = i_signed;
          addr_n  = req_addr;
          wdata_n = i_wdata;
          beat_n  = '0;
          acc_n   = '0;
          state_n = bad ? ERR : ISSUE;
        end
      end
      ISSUE: begin
        if (!we_q && beat_q != 2'd0) acc_n = word_val;
        if (last) state_n = we_q ? DONE : WAIT;
        else      beat_n  = beat_q + 2'd1;
      end
      WAIT: begin
        rdata_n = extend(sz_q, sgn_q, (sz_q == 2'b10) ? word_val : sub_val);
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase

    // memory-side outputs are computed for the next state so they come straight off flops
    issue_n = (state_n == ISSUE);
    ready_n = (state_n == IDLE);
    done_n  = (state_n == DONE);
`ifdef MEM_ACCESS_SEQ_ALIGN_CHECK_EN
    err_n   = (state_n == ERR);
`else
    err_n   = 1'b0;
`endif
    en_n    = issue_n;
    rd_en_n = issue_n && !we_n;
    maddr_n = issue_n ? MEM_AW'(addr_n >> LANE_BITS) + MEM_AW'(beat_n) : '0;
    off_n   = 2'(addr_n[LANE_BITS-1:0]);
    di_n    = '0;
    wr_en_n = '0;
    if (issue_n && we_n) begin
      for (int k = 0; k < LANES; k++) begin
        case (sz_n)
          2'b00: begin
            di_n[k]    = wdata_n[7:0];
            wr_en_n[k] = (2'(k) == off_n);
          end
          2'b01: begin
            di_n[k]    = wdata_n[8*(k%2) +: 8];
            wr_en_n[k] = (2'(k) == off_n) || (2'(k) == off_n + 2'd1);
          end
          default: begin
            for (int j = 0; j < 4; j++)
              if (int'(beat_n)*LANES + k == j) di_n[k] = wdata_n[8*j +: 8];
            wr_en_n[k] = 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq (LANES=2): directed scenarios plus random accesses checked
// against a byte-addressed reference memory.
module tb_mem_access_seq;
  localparam int MEM_DEPTH = 4096;
  localparam int LANES     = 2;
  localparam int AW        = 13;
  localparam int MAW       = 12;
  localparam int NBYTES    = MEM_DEPTH*LANES;
`ifdef MEM_ACCESS_SEQ_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_req, i_we, i_signed;
  logic [1:0]            i_size;
  logic [AW-1:0]         i_addr;
  logic [31:0]           i_wdata;
  logic                  o_ready, o_done, o_err;
  logic [31:0]           o_rdata;
  logic [0:LANES-1][7:0] i_mem_do, o_mem_di;
  logic [MAW-1:0]        o_mem_addr;
  logic                  o_mem_en, o_mem_rd_en;
  logic [0:LANES-1]      o_mem_wr_en;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rd;
  logic ram_init;
  logic [0:LANES-1][7:0] ram [MEM_DEPTH];
  logic [7:0] ref_mem [NBYTES];

  always #5 clk = ~clk;

  mem_access_seq #(.MEM_DEPTH(MEM_DEPTH), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_size(i_size), .i_signed(i_signed),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready), .o_done(o_done), .o_rdata(o_rdata),
    .o_err(o_err), .i_mem_do(i_mem_do), .o_mem_di(o_mem_di), .o_mem_addr(o_mem_addr),
    .o_mem_en(o_mem_en), .o_mem_rd_en(o_mem_rd_en), .o_mem_wr_en(o_mem_wr_en));

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a*37 + 11) ^ (a >> 5));
  endfunction

  // synchronous single-port RAM, one cycle read latency
  always @(posedge clk) begin
    if (ram_init) begin
      for (int w = 0; w < MEM_DEPTH; w++)
        for (int k = 0; k < LANES; k++) ram[w][k] <= init_byte(w*LANES + k);
      i_mem_do <= '0;
    end else if (o_mem_en) begin
      for (int k = 0; k < LANES; k++)
        if (o_mem_wr_en[k]) ram[o_mem_addr][k] <= o_mem_di[k];
      if (o_mem_rd_en) i_mem_do <= ram[o_mem_addr];
    end
  end

  function automatic int sbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit rejected(input logic [1:0] sz, input logic [AW-1:0] a);
    return ALIGN_CHK && ((sz == 2'b11) || (int'(a) % sbytes(sz) != 0));
  endfunction

  function automatic logic [AW-1:0] eff_addr(input logic [1:0] sz, input logic [AW-1:0] a);
    return ALIGN_CHK ? a : AW'((int'(a) / sbytes(sz)) * sbytes(sz));
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn, input logic [AW-1:0] a);
    logic [31:0]   v;
    logic [AW-1:0] ea;
    v  = '0;
    ea = eff_addr(sz, a);
    for (int i = 0; i < 4; i++)
      if (i < sbytes(sz)) v[8*i +: 8] = ref_mem[ea + AW'(i)];
    if (sgn && sz == 2'b00) v = {{24{v[7]}}, v[7:0]};
    if (sgn && sz == 2'b01) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] wd);
    logic [AW-1:0] ea;
    ea = eff_addr(sz, a);
    for (int i = 0; i < 4; i++)
      if (i < sbytes(sz)) ref_mem[ea + AW'(i)] = wd[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic start(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [AW-1:0] a, input logic [31:0] wd);
    i_req = 1'b1; i_we = we; i_size = sz; i_signed = sgn; i_addr = a; i_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    i_req = 1'b0;
  endtask

  // full access with timing, beat count, flags and load data checked against the model
  task automatic access(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [AW-1:0] a, input logic [31:0] wd, input string tag);
    int cyc, beats, exp_cyc, exp_beats;
    bit exp_rej, fin;
    logic [31:0] exp_rd;
    exp_rej   = rejected(sz, a);
    exp_beats = exp_rej ? 0 : ((sbytes(sz) == 4 && LANES == 2) ? 2 : 1);
    exp_cyc   = exp_rej ? 1 : (we ? exp_beats + 1 : exp_beats + 2);
    exp_rd    = ref_load(sz, sgn, a);
    chk({tag, " ready_before"}, 32'(o_ready), 32'd1);
    start(we, sz, sgn, a, wd);
    cyc = 1; beats = 0; fin = 1'b0;
    while (!fin && cyc <= 12) begin
      if (o_mem_en) beats++;
      if (o_done || o_err) begin
        fin = 1'b1;
        i_req = 1'b0;
        last_rd = o_rdata;
      end else begin
        // junk on the request port while busy must be ignored
        i_req = 1'($urandom); i_we = 1'($urandom); i_size = 2'($urandom);
        i_addr = AW'($urandom); i_wdata = $urandom; i_signed = 1'($urandom);
        @(negedge clk);
        cyc++;
      end
    end
    i_req = 1'b0;
    chk({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " err"}, 32'(o_err), 32'(exp_rej));
    chk({tag, " done"}, 32'(o_done), 32'(!exp_rej));
    chk({tag, " beats"}, 32'(beats), 32'(exp_beats));
    if (!we && !exp_rej) chk({tag, " rdata"}, last_rd, exp_rd);
    if (we && !exp_rej) ref_store(sz, a, wd);
    @(negedge clk);
    chk({tag, " ready_after"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    logic we, sgn;
    logic [1:0] sz;
    logic [AW-1:0] a;
    rst = 1'b1; ram_init = 1'b1;
    i_req = 1'b0; i_we = 1'b0; i_size = '0; i_signed = 1'b0; i_addr = '0; i_wdata = '0;
    for (int b = 0; b < NBYTES; b++) ref_mem[b] = init_byte(b);
    @(negedge clk);
    @(negedge clk);
    chk("rst ready", 32'(o_ready), 32'd1);
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst err", 32'(o_err), 32'd0);
    chk("rst mem_en", 32'(o_mem_en), 32'd0);
    chk("rst rd_en", 32'(o_mem_rd_en), 32'd0);
    chk("rst wr_en", 32'(o_mem_wr_en), 32'd0);
    chk("rst rdata", o_rdata, 32'd0);
    chk("rst di", 32'(o_mem_di), 32'd0);
    chk("rst addr", 32'(o_mem_addr), 32'd0);
    ram_init = 1'b0; rst = 1'b0;
    @(negedge clk);

    // word store 0xA1B2C3D4 at 0x0010
    start(1'b1, 2'b10, 1'b0, 13'h0010, 32'hA1B2C3D4);
    chk("s1 c1 en", 32'(o_mem_en), 32'd1);
    chk("s1 c1 addr", 32'(o_mem_addr), 32'd8);
    chk("s1 c1 wr_en", 32'(o_mem_wr_en), 32'h3);
    chk("s1 c1 lanes", 32'(o_mem_di), 32'hD4C3);
    @(negedge clk);
    chk("s1 c2 addr", 32'(o_mem_addr), 32'd9);
    chk("s1 c2 wr_en", 32'(o_mem_wr_en), 32'h3);
    chk("s1 c2 lanes", 32'(o_mem_di), 32'hB2A1);
    @(negedge clk);
    chk("s1 c3 done", 32'(o_done), 32'd1);
    chk("s1 c3 en", 32'(o_mem_en), 32'd0);
    ref_store(2'b10, 13'h0010, 32'hA1B2C3D4);
    @(negedge clk);
    chk("s1 c4 ready", 32'(o_ready), 32'd1);

    // word load back from 0x0010
    start(1'b0, 2'b10, 1'b0, 13'h0010, 32'h0);
    chk("s2 c1 rd_en", 32'(o_mem_rd_en), 32'd1);
    chk("s2 c1 addr", 32'(o_mem_addr), 32'd8);
    @(negedge clk);
    chk("s2 c2 addr", 32'(o_mem_addr), 32'd9);
    chk("s2 c2 rd_en", 32'(o_mem_rd_en), 32'd1);
    @(negedge clk);
    chk("s2 c3 en", 32'(o_mem_en), 32'd0);
    chk("s2 c3 done", 32'(o_done), 32'd0);
    @(negedge clk);
    chk("s2 c4 done", 32'(o_done), 32'd1);
    chk("s2 c4 rdata", o_rdata, 32'hA1B2C3D4);
    @(negedge clk);

    // signed / unsigned byte load from 0x0013
    start(1'b0, 2'b00, 1'b1, 13'h0013, 32'h0);
    chk("s3 c1 addr", 32'(o_mem_addr), 32'd9);
    @(negedge clk);
    @(negedge clk);
    chk("s3 c3 done", 32'(o_done), 32'd1);
    chk("s3 c3 rdata_s", o_rdata, 32'hFFFFFFA1);
    @(negedge clk);
    access(1'b0, 2'b00, 1'b0, 13'h0013, 32'h0, "s3u");
    chk("s3 rdata_u", last_rd, 32'h000000A1);

    // byte store 0x55 at 0x0011, then word reload
    start(1'b1, 2'b00, 1'b0, 13'h0011, 32'h00000055);
    chk("s4 c1 addr", 32'(o_mem_addr), 32'd8);
    chk("s4 c1 wr_en", 32'(o_mem_wr_en), 32'h1);
    chk("s4 c1 lanes", 32'(o_mem_di), 32'h5555);
    @(negedge clk);
    chk("s4 c2 done", 32'(o_done), 32'd1);
    ref_store(2'b00, 13'h0011, 32'h00000055);
    @(negedge clk);
    access(1'b0, 2'b10, 1'b0, 13'h0010, 32'h0, "s4l");
    chk("s4 rdata", last_rd, 32'hA1B255D4);

    // misaligned word load: rejected with the check enabled, otherwise reads 0x0010
    access(1'b0, 2'b10, 1'b0, 13'h0012, 32'h0, "s5");
    access(1'b0, 2'b11, 1'b0, 13'h0010, 32'h0, "s5sz");

    // reset in the middle of a word store
    start(1'b1, 2'b10, 1'b0, 13'h0020, 32'h11223344);
    chk("s6 c1 wr_en", 32'(o_mem_wr_en), 32'h3);
    #2 rst = 1'b1;
    #1;
    chk("s6 rst wr_en", 32'(o_mem_wr_en), 32'd0);
    chk("s6 rst en", 32'(o_mem_en), 32'd0);
    chk("s6 rst ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s6 post done", 32'(o_done), 32'd0);
    chk("s6 post ready", 32'(o_ready), 32'd1);
    access(1'b0, 2'b10, 1'b0, 13'h0020, 32'h0, "s6 untouched");
    access(1'b1, 2'b10, 1'b0, 13'h0020, 32'h11223344, "s6 store");
    access(1'b0, 2'b10, 1'b0, 13'h0020, 32'h0, "s6 load");

    // top-of-memory boundaries
    access(1'b1, 2'b10, 1'b0, 13'h1FFC, 32'hCAFEF00D, "top store");
    access(1'b0, 2'b10, 1'b0, 13'h1FFC, 32'h0, "top load");
    access(1'b0, 2'b00, 1'b1, 13'h1FFF, 32'h0, "top byte");
    access(1'b0, 2'b01, 1'b1, 13'h1FFE, 32'h0, "top half");

    for (int t = 0; t < 80; t++) begin
      we  = 1'($urandom);
      sz  = 2'($urandom);
      sgn = 1'($urandom);
      a   = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~AW'(sbytes(sz) - 1);
      access(we, sz, sgn, a, $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
